mux_41_4: RTL and testbench
===========================

Name: mux_41_4

Overview:
- 4-to-1 multiplexer: one of four WIDTH-bit data words is chosen by a 2-bit select and driven to the output.
- The output is registered, giving one clock of latency.
- Used as a generic datapath word selector; it is a leaf block with no handshake to upstream logic.
- Default instance is 4 bits wide, with one-hot test words 0001/0010/0100/1000 as the canonical check pattern.

Parameters:
- WIDTH, 4, bit width of each data input and of the output.
- RST_VAL, {WIDTH{1'b0}}, value loaded into o_f on reset.

Ports:
- i_clk  input  1  system clock; all state updates on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  load enable for the output register; when low, o_f holds.
- i_s  input  2  select: 00 picks i_w0, 01 picks i_w1, 10 picks i_w2, 11 picks i_w3.
- i_w0  input  WIDTH  data word 0.
- i_w1  input  WIDTH  data word 1.
- i_w2  input  WIDTH  data word 2.
- i_w3  input  WIDTH  data word 3.
- o_f  output  WIDTH  registered selected word.
- o_s  output  2  registered copy of the select that produced the current o_f.
- o_vld  output  1  high once o_f holds a selected word (not the reset value).

Behaviour:
- Combinational select:
  - sel_w = i_w0/i_w1/i_w2/i_w3 for i_s = 0/1/2/3.
  - Full case. If i_s contains X/Z, sel_w is all-X in simulation; no latch may be inferred.
- Reset:
  - While i_rst = 1, regardless of i_clk: o_f = RST_VAL, o_s = 2'b00, o_vld = 0.
  - Deassertion takes effect at the next rising edge of i_clk.
- Rising edge of i_clk with i_rst = 0 and i_en = 1:
  - o_f <= sel_w.
  - o_s <= i_s.
  - o_vld <= 1.
- Rising edge with i_en = 0: o_f, o_s and o_vld all hold their values.
- Latency: exactly one clock from i_s or i_w* to o_f. There is no combinational path from any input to any output.
- Select changes: when i_s changes every cycle, o_f follows with a one-cycle lag and skips nothing. After i_s = 11, wrap-around to 00 selects i_w0 on the following edge.
- Data changes: a change on a data word that is not currently selected has no effect on o_f.
- Reset mid-stream: o_f returns to RST_VAL immediately (asynchronously). o_vld goes low and stays low until the first enabled edge after reset release.
- Width: all data paths are WIDTH bits. There is no arithmetic, extension or truncation.

Decomposition:
- Shared package mux_41_4_pkg:
  - localparams SEL_W0 = 2'd0, SEL_W1 = 2'd1, SEL_W2 = 2'd2, SEL_W3 = 2'd3.
  - SEL_BITS = 2.
- One sub-module, mux_41_4_comb:
  - Purely combinational, parameterised by WIDTH.
  - Performs the case-based selection.
  - The top level instantiates it and adds the output register, o_s, o_vld and the reset/enable logic.

Test Plan:
- Reset check: hold i_rst = 1 with w0..w3 = 0001/0010/0100/1000 and i_s = 00 -> o_f = 0000, o_s = 00, o_vld = 0, including between clock edges.
- Select sweep: release reset with i_en = 1 and step i_s 00,01,10,11 once per clock -> one cycle later o_f = 0001, 0010, 0100, 1000 respectively and o_vld = 1.
- Wrap-around: step i_s 11 -> 00 -> o_f goes 1000 then 0001; o_s tracks with one-cycle lag.
- Enable hold: i_s = 10 loaded (o_f = 0100), then i_en = 0 while i_s changes to 01 and i_w2 changes to 1111 -> o_f stays 0100 for all held cycles.
- Unselected isolation: i_s = 01 and i_en = 1; toggle i_w0, i_w2 and i_w3 every cycle -> o_f stays 0010. Change i_w1 to 1010 -> o_f = 1010 on the next edge.
- Async reset mid-stream: assert i_rst between clock edges while o_f = 1000 -> o_f = 0000 and o_vld = 0 immediately. After release, the first enabled edge with i_s = 01 gives o_f = 0010.

Source files
------------

// File: rtl/mux_41_4_pkg.sv
// Shared select encodings for the registered 4-to-1 word multiplexer.
package mux_41_4_pkg;

    localparam int SEL_BITS = 2;

    localparam logic [SEL_BITS-1:0] SEL_W0 = 2'd0;
    localparam logic [SEL_BITS-1:0] SEL_W1 = 2'd1;
    localparam logic [SEL_BITS-1:0] SEL_W2 = 2'd2;
    localparam logic [SEL_BITS-1:0] SEL_W3 = 2'd3;

endpackage : mux_41_4_pkg

// File: rtl/mux_41_4_comb.sv
// Combinational word selector: picks one of four WIDTH-bit words by a 2-bit select.
module mux_41_4_comb
    import mux_41_4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [SEL_BITS-1:0] s_i,
    input  logic [WIDTH-1:0]    w0_i,
    input  logic [WIDTH-1:0]    w1_i,
    input  logic [WIDTH-1:0]    w2_i,
    input  logic [WIDTH-1:0]    w3_i,
    output logic [WIDTH-1:0]    sel_w_o
);

    // An unknown select propagates as all-X so bad selects are visible in simulation.
    always_comb begin
        sel_w_o = {WIDTH{1'bx}};
        case (s_i)
            SEL_W0:  sel_w_o = w0_i;
            SEL_W1:  sel_w_o = w1_i;
            SEL_W2:  sel_w_o = w2_i;
            SEL_W3:  sel_w_o = w3_i;
            default: sel_w_o = {WIDTH{1'bx}};
        endcase
    end

endmodule : mux_41_4_comb

// File: rtl/mux_41_4.sv
// Registered 4-to-1 word multiplexer: one clock of latency, load enable,
// registered select echo and a valid flag that drops on reset.
module mux_41_4
    import mux_41_4_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [SEL_BITS-1:0] i_s,
    input  logic [WIDTH-1:0]    i_w0,
    input  logic [WIDTH-1:0]    i_w1,
    input  logic [WIDTH-1:0]    i_w2,
    input  logic [WIDTH-1:0]    i_w3,
    output logic [WIDTH-1:0]    o_f,
    output logic [SEL_BITS-1:0] o_s,
    output logic                o_vld
);

    logic [WIDTH-1:0]    sel_w;
    logic [WIDTH-1:0]    f_q,   f_d;
    logic [SEL_BITS-1:0] s_q,   s_d;
    logic                vld_q, vld_d;

    mux_41_4_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .s_i     (i_s),
        .w0_i    (i_w0),
        .w1_i    (i_w1),
        .w2_i    (i_w2),
        .w3_i    (i_w3),
        .sel_w_o (sel_w)
    );

    always_comb begin
        f_d   = f_q;
        s_d   = s_q;
        vld_d = vld_q;
        if (i_en) begin
            f_d   = sel_w;
            s_d   = i_s;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_q   <= RST_VAL;
            s_q   <= SEL_W0;
            vld_q <= 1'b0;
        end else begin
            f_q   <= f_d;
            s_q   <= s_d;
            vld_q <= vld_d;
        end
    end

    assign o_f   = f_q;
    assign o_s   = s_q;
    assign o_vld = vld_q;

endmodule : mux_41_4

// File: tb/tb_mux_41_4.sv
// Directed bench for mux_41_4: vector table for the clocked behaviour plus
// hand sequences for reset, combinational-path absence and mid-stream reset.
module tb_mux_41_4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] s;
    logic [3:0] w0, w1, w2, w3;
    logic [3:0] f;
    logic [1:0] fs;
    logic       vld;

    int checks = 0;
    int errors = 0;

    mux_41_4 #(
        .WIDTH   (4),
        .RST_VAL (4'b0000)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (en),
        .i_s   (s),
        .i_w0  (w0),
        .i_w1  (w1),
        .i_w2  (w2),
        .i_w3  (w3),
        .o_f   (f),
        .o_s   (fs),
        .o_vld (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [1:0] s;
        logic [3:0] w0;
        logic [3:0] w1;
        logic [3:0] w2;
        logic [3:0] w3;
        logic [3:0] ef;
        logic [1:0] es;
        logic       ev;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ef, input logic [1:0] es, input logic ev);
        chk({tag, " o_f"},   f,            ef);
        chk({tag, " o_s"},   {2'b00, fs},  {2'b00, es});
        chk({tag, " o_vld"}, {3'b000, vld}, {3'b000, ev});
    endtask

    initial begin
        // en, s, w0, w1, w2, w3, expected o_f, o_s, o_vld after the edge
        vec[0]  = {1'b1, 2'd0, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 2'd0, 1'b1};
        vec[1]  = {1'b1, 2'd1, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 2'd1, 1'b1};
        vec[2]  = {1'b1, 2'd2, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 2'd2, 1'b1};
        vec[3]  = {1'b1, 2'd3, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vec[4]  = {1'b1, 2'd0, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 2'd0, 1'b1};
        vec[5]  = {1'b1, 2'd3, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vec[6]  = {1'b1, 2'd0, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 2'd0, 1'b1};
        vec[7]  = {1'b1, 2'd2, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 2'd2, 1'b1};
        vec[8]  = {1'b0, 2'd1, 4'b0001, 4'b0010, 4'b1111, 4'b1000, 4'b0100, 2'd2, 1'b1};
        vec[9]  = {1'b0, 2'd1, 4'b0001, 4'b0010, 4'b1111, 4'b1000, 4'b0100, 2'd2, 1'b1};
        vec[10] = {1'b0, 2'd3, 4'b0001, 4'b0010, 4'b1111, 4'b1000, 4'b0100, 2'd2, 1'b1};
        vec[11] = {1'b1, 2'd1, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 2'd1, 1'b1};
        vec[12] = {1'b1, 2'd1, 4'b1110, 4'b0010, 4'b1011, 4'b0111, 4'b0010, 2'd1, 1'b1};
        vec[13] = {1'b1, 2'd1, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 2'd1, 1'b1};
        vec[14] = {1'b1, 2'd1, 4'b1111, 4'b0010, 4'b0000, 4'b1111, 4'b0010, 2'd1, 1'b1};
        vec[15] = {1'b1, 2'd1, 4'b1111, 4'b1010, 4'b0000, 4'b1111, 4'b1010, 2'd1, 1'b1};
        vec[16] = {1'b1, 2'd3, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 2'd3, 1'b1};

        rst = 1'b1;
        en  = 1'b1;
        s   = 2'd0;
        w0  = 4'b0001;
        w1  = 4'b0010;
        w2  = 4'b0100;
        w3  = 4'b1000;

        // Reset holds outputs low both between edges and across edges.
        #1;
        chk_all("reset t1", 4'b0000, 2'd0, 1'b0);
        @(posedge clk); #1;
        chk_all("reset edge1", 4'b0000, 2'd0, 1'b0);
        @(posedge clk); #3;
        chk_all("reset midcycle", 4'b0000, 2'd0, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            en = vec[i].en;
            s  = vec[i].s;
            w0 = vec[i].w0;
            w1 = vec[i].w1;
            w2 = vec[i].w2;
            w3 = vec[i].w3;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vec[i].ef, vec[i].es, vec[i].ev);
            @(negedge clk);
        end

        // No combinational path: input changes between edges leave outputs alone.
        s  = 2'd0;
        w3 = 4'b0110;
        w0 = 4'b1001;
        #2;
        chk_all("no comb path", 4'b1000, 2'd3, 1'b1);
        s  = 2'd3;
        w3 = 4'b1000;
        w0 = 4'b0001;

        // Asynchronous reset between edges while o_f = 1000.
        #1;
        rst = 1'b1;
        #1;
        chk_all("async rst", 4'b0000, 2'd0, 1'b0);
        en = 1'b1;
        s  = 2'd1;
        @(posedge clk); #1;
        chk_all("rst held edge", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk); #1;
        chk_all("post rst no en", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        chk_all("post rst first en", 4'b0010, 2'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_41_4
